// File: rtl/fog_uart_frame_tx_if.sv
// Bus bundle between the FOG sampling logic and the frame transmitter.
// Handshake: a frame request is i_trig high for one cycle while i_en is high;
// it is taken only when the transmitter is idle (o_busy low), otherwise it is
// counted in o_drop_cnt. There is no back-pressure; o_busy tells the requester
// whether its next trigger will be taken or dropped.
interface fog_uart_frame_tx_if;
  logic        i_en;
  logic        i_trig;
  logic [31:0] i_step;
  logic [31:0] i_err;
  logic        o_tx;
  logic        o_busy;
  logic        o_frame_done;
  logic [15:0] o_drop_cnt;

  // Requester side: drives enable/trigger/data, observes line and status.
  modport master (
    output i_en, i_trig, i_step, i_err,
    input  o_tx, o_busy, o_frame_done, o_drop_cnt
  );

  // Transmitter side.
  modport slave (
    input  i_en, i_trig, i_step, i_err,
    output o_tx, o_busy, o_frame_done, o_drop_cnt
  );
endinterface

// File: rtl/fog_uart_frame_tx.sv
// FOG-to-CPU link transmitter: snapshots step/error words on an accepted
// trigger and sends a 12-byte frame (header, step, err, seq, xor checksum)
// as UART 8N1 with no gaps between bytes.
module fog_uart_frame_tx #(
  parameter int         CLK_DIV = 868,
  parameter logic [7:0] HEADER0 = 8'hAB,
  parameter logic [7:0] HEADER1 = 8'hBA
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  fog_uart_frame_tx_if.slave  bus,
  output logic [2:0]          o_dbg_state
);

  localparam int                DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       bit_q, bit_d;
  logic [3:0]       byte_q, byte_d;
  logic [31:0]      step_q, step_d;
  logic [31:0]      err_q, err_d;
  logic [7:0]       seq_q, seq_d;
  logic [7:0]       fseq_q, fseq_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [15:0]      drop_q, drop_d;

  logic             accept;
  logic             drop_hit;
  logic             div_last;
  logic [7:0]       chk;
  logic [7:0]       cur_byte;

  assign accept   = (state_q == S_IDLE) && bus.i_en && bus.i_trig;
  assign drop_hit = busy_q && bus.i_en && bus.i_trig;
  assign div_last = (div_q == DIV_LAST);

  // Checksum over the payload bytes, taken from the shadow copies only.
  assign chk = step_q[31:24] ^ step_q[23:16] ^ step_q[15:8] ^ step_q[7:0] ^
               err_q[31:24]  ^ err_q[23:16]  ^ err_q[15:8]  ^ err_q[7:0]  ^
               fseq_q;

  // Byte currently on the line, selected by frame position.
  always_comb begin
    cur_byte = chk;
    case (byte_q)
      4'd0:    cur_byte = HEADER0;
      4'd1:    cur_byte = HEADER1;
      4'd2:    cur_byte = step_q[31:24];
      4'd3:    cur_byte = step_q[23:16];
      4'd4:    cur_byte = step_q[15:8];
      4'd5:    cur_byte = step_q[7:0];
      4'd6:    cur_byte = err_q[31:24];
      4'd7:    cur_byte = err_q[23:16];
      4'd8:    cur_byte = err_q[15:8];
      4'd9:    cur_byte = err_q[7:0];
      4'd10:   cur_byte = fseq_q;
      default: cur_byte = chk;
    endcase
  end

  // Next-state logic. tx_d is the line level for the state being left, so
  // the registered o_tx trails the FSM by one cycle; S_DONE absorbs that
  // cycle so the final stop bit still lasts a full CLK_DIV.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    step_d  = step_q;
    err_d   = err_q;
    seq_d   = seq_q;
    fseq_d  = fseq_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    tx_d    = 1'b1;
    drop_d  = drop_q;

    if (drop_hit && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end

    case (state_q)
      S_IDLE: begin
        div_d  = '0;
        bit_d  = '0;
        byte_d = '0;
        if (accept) begin
          state_d = S_START;
          step_d  = bus.i_step;
          err_d   = bus.i_err;
          fseq_d  = seq_q;
          busy_d  = 1'b1;
        end
      end
      S_START: begin
        tx_d = 1'b0;
        if (div_last) begin
          div_d   = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_DATA: begin
        tx_d = cur_byte[bit_q];
        if (div_last) begin
          div_d = '0;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (div_last) begin
          div_d = '0;
          if (byte_q == 4'd11) begin
            state_d = S_DONE;
          end else begin
            byte_d  = byte_q + 4'd1;
            state_d = S_START;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_DONE: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        seq_d   = seq_q + 8'd1;
        byte_d  = '0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset forces an idle, high line at once.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      step_q  <= '0;
      err_q   <= '0;
      seq_q   <= '0;
      fseq_q  <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      step_q  <= step_d;
      err_q   <= err_d;
      seq_q   <= seq_d;
      fseq_q  <= fseq_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.o_tx         = tx_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_frame_done = done_q;
  assign bus.o_drop_cnt   = drop_q;
  assign o_dbg_state      = state_q;

endmodule

// File: tb/tb_fog_uart_frame_tx.sv
// Bench for fog_uart_frame_tx: a frame-level model queues expected bytes on
// every accepted trigger; a UART receiver monitor decodes o_tx and checks
// bytes against the queue; a cycle checker compares status outputs.
module tb_fog_uart_frame_tx;
  localparam int CLK_DIV   = 4;
  localparam int FRAME_CYC = 120 * CLK_DIV;

  logic       clk;
  logic       rst_n;
  logic [2:0] dbg_state;

  fog_uart_frame_tx_if bus();

  fog_uart_frame_tx #(.CLK_DIV(CLK_DIV)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [7:0]  exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  int          epoch    = 0;
  int          mdl_acc  = -100000;
  int          mdl_free = 0;
  logic [7:0]  mdl_seq  = 8'd0;
  logic [15:0] mdl_drop = 16'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Expected frame built from the byte layout rules.
  task automatic push_frame(input logic [31:0] s, input logic [31:0] e, input logic [7:0] sq);
    logic [7:0] b[12];
    logic [7:0] x;
    b[0] = 8'hAB;
    b[1] = 8'hBA;
    for (int k = 0; k < 4; k++) begin
      b[2 + k] = 8'(s >> (24 - 8 * k));
      b[6 + k] = 8'(e >> (24 - 8 * k));
    end
    b[10] = sq;
    x = 8'h00;
    for (int k = 2; k <= 10; k++) x = x ^ b[k];
    b[11] = x;
    for (int k = 0; k < 12; k++) exp_q.push_back(b[k]);
  endtask

  // Reference model: decides accept/drop per sampled trigger.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        mdl_seq  = 8'd0;
        mdl_drop = 16'd0;
        mdl_free = 0;
        mdl_acc  = -100000;
      end else if (bus.i_en && bus.i_trig) begin
        if (cyc >= mdl_free) begin
          mdl_acc  = cyc;
          mdl_free = cyc + 2 + FRAME_CYC;
          push_frame(bus.i_step, bus.i_err, mdl_seq);
          mdl_seq  = mdl_seq + 8'd1;
        end else if (mdl_drop != 16'hFFFF) begin
          mdl_drop = mdl_drop + 16'd1;
        end
      end
    end
  end

  // Status checker on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && cyc > 2) begin
        check("busy", 32'(bus.o_busy),
              32'((cyc >= mdl_acc) && (cyc < mdl_acc + 1 + FRAME_CYC)));
        check("frame_done", 32'(bus.o_frame_done), 32'(cyc == mdl_acc + 1 + FRAME_CYC));
        check("drop_cnt", 32'(bus.o_drop_cnt), 32'(mdl_drop));
        if (!((cyc >= mdl_acc + 1) && (cyc <= mdl_acc + FRAME_CYC)))
          check("idle_tx", 32'(bus.o_tx), 32'd1);
      end
    end
  end

  // UART receiver monitor: samples each bit mid-way and scores the byte.
  initial begin
    logic [9:0] bits;
    int         ep;
    forever begin
      @(negedge clk);
      if (rst_n && bus.o_tx === 1'b0) begin
        ep = epoch;
        for (int i = 0; i < 10; i++) begin
          repeat ((i == 0) ? 1 : CLK_DIV) @(negedge clk);
          bits[i] = bus.o_tx;
        end
        if (ep == epoch && rst_n) begin
          check("start_bit", 32'(bits[0]), 32'd0);
          check("stop_bit", 32'(bits[9]), 32'd1);
          if (exp_q.size() == 0) begin
            check("byte_expected", 32'(bits[8:1]), 32'hxxxxxxxx);
          end else begin
            check("byte", 32'(bits[8:1]), 32'(exp_q.pop_front()));
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_trig();
    @(negedge clk);
    bus.i_trig = 1'b1;
    @(negedge clk);
    bus.i_trig = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int   n;
    logic seen;
    n    = 0;
    seen = 1'b0;
    while (n < budget && !seen) begin
      @(negedge clk);
      if (bus.o_frame_done) seen = 1'b1;
      n++;
    end
    check("frame_done_seen", 32'(seen), 32'd1);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    epoch++;
    exp_q.delete();
    #1;
    check("rst_tx", 32'(bus.o_tx), 32'd1);
    check("rst_busy", 32'(bus.o_busy), 32'd0);
    check("rst_done", 32'(bus.o_frame_done), 32'd0);
    check("rst_drop", 32'(bus.o_drop_cnt), 32'd0);
    repeat (20) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n      = 1'b0;
    bus.i_en   = 1'b0;
    bus.i_trig = 1'b0;
    bus.i_step = 32'h0;
    bus.i_err  = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(bus.o_tx), 32'd1);
    check("rst_busy", 32'(bus.o_busy), 32'd0);
    check("rst_done", 32'(bus.o_frame_done), 32'd0);
    check("rst_drop", 32'(bus.o_drop_cnt), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Reference frame: AB BA 12 34 56 78 FF FF FF F6 00 01.
    bus.i_en   = 1'b1;
    bus.i_step = 32'h12345678;
    bus.i_err  = 32'hFFFFFFF6;
    do_trig();
    wait_done(1000);
    repeat (10) @(negedge clk);

    // Back-to-back: second trigger in the frame_done cycle.
    do_trig();
    wait_done(1000);
    bus.i_trig = 1'b1;
    @(negedge clk);
    bus.i_trig = 1'b0;
    @(negedge clk);
    check("start_latency", 32'(bus.o_tx), 32'd0);
    wait_done(1000);
    repeat (10) @(negedge clk);

    // Three triggers during an active frame, and input change after accept.
    do_trig();
    bus.i_step = 32'h0;
    repeat (8) @(negedge clk);
    do_trig();
    repeat (38) @(negedge clk);
    do_trig();
    repeat (48) @(negedge clk);
    do_trig();
    wait_done(1000);
    bus.i_step = 32'h12345678;
    repeat (5) @(negedge clk);

    // Enable falls mid-frame: frame completes, later triggers ignored.
    do_trig();
    repeat (100) @(negedge clk);
    bus.i_en = 1'b0;
    do_trig();
    wait_done(1000);
    do_trig();
    repeat (40) @(negedge clk);
    bus.i_en = 1'b1;
    repeat (5) @(negedge clk);

    // Randomized frames with stray triggers and random enable.
    for (int f = 0; f < 8; f++) begin
      bus.i_step = $urandom;
      bus.i_err  = $urandom;
      do_trig();
      for (int j = 0; j < int'($urandom_range(0, 3)); j++) begin
        repeat ($urandom_range(5, 100)) @(negedge clk);
        bus.i_en = 1'($urandom_range(0, 1));
        do_trig();
        bus.i_en = 1'b1;
      end
      wait_done(1000);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    repeat (5) @(negedge clk);

    // Reset during byte 5, then a fresh frame must restart seq at 00.
    bus.i_step = 32'h12345678;
    bus.i_err  = 32'hFFFFFFF6;
    do_trig();
    repeat (5 * 10 * CLK_DIV + 10) @(negedge clk);
    apply_reset();
    do_trig();
    wait_done(1000);
    repeat (20) @(negedge clk);

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
